// File: rtl/mem_access_unit.sv
// Load/store stage: runs one request/acknowledge transaction per op, aligns lanes, extends loads, flags faults.
// Latency: req the cycle after accept; load write-back the cycle after ack. Stalls upstream (oBusy) while not IDLE.
module mem_access_unit #(
    parameter int pXLEN    = 32,
    parameter int pMaxWait = 15
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iMemDv,
    input  logic               iMemRead,
    input  logic               iMemWrite,
    input  logic [pXLEN-1:0]   iMemAddr,
    input  logic [pXLEN-1:0]   iMemData,
    input  logic [2:0]         iMemOpType,
    input  logic [4:0]         iMemRdAddr,
    output logic               oBusy,
    output logic               oDmemReq,
    output logic               oDmemWe,
    output logic [pXLEN-1:0]   oDmemAddr,
    output logic [pXLEN-1:0]   oDmemWData,
    output logic [pXLEN/8-1:0] oDmemBe,
    input  logic               iDmemAck,
    input  logic [pXLEN-1:0]   iDmemRData,
    output logic               oRegDv,
    output logic [4:0]         oRegAddr,
    output logic [pXLEN-1:0]   oRegData,
    output logic               oErr,
    output logic [1:0]         oErrCode
);
    typedef enum logic [1:0] {IDLE, BUSREQ, WB} state_t;

    localparam logic [7:0] MAX_WAIT = 8'(pMaxWait);
    localparam int         BW       = pXLEN / 8;

    state_t             state, state_nxt;
    logic [7:0]         wait_cnt, wait_cnt_nxt;
    logic               op_load, op_load_nxt;
    logic [2:0]         op_f3, op_f3_nxt;
    logic [1:0]         op_off, op_off_nxt;
    logic               req_nxt, we_nxt, regdv_nxt, err_nxt;
    logic [pXLEN-1:0]   addr_nxt, wdata_nxt, regdata_nxt;
    logic [BW-1:0]      be_nxt;
    logic [4:0]         regaddr_nxt;
    logic [1:0]         errcode_nxt;

    logic               accept, width_ok, misal;
    logic [pXLEN-1:0]   st_wdata, ld_shift, ld_data;
    logic [BW-1:0]      st_be;

    assign oBusy  = (state != IDLE);
    assign accept = iMemDv & (iMemRead | iMemWrite);

    // A set read strobe wins, so both strobes high is treated as a load.
    always_comb begin
        if (iMemRead) width_ok = iMemOpType inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else          width_ok = iMemOpType inside {3'b000, 3'b001, 3'b010};
        misal = ((iMemOpType[1:0] == 2'b01) && iMemAddr[0]) ||
                ((iMemOpType[1:0] == 2'b10) && (iMemAddr[1:0] != 2'b00));
    end

    always_comb begin
        case (iMemOpType[1:0])
            2'b00: begin
                st_wdata = {BW{iMemData[7:0]}};
                st_be    = BW'(1) << iMemAddr[1:0];
            end
            2'b01: begin
                st_wdata = {(BW/2){iMemData[15:0]}};
                st_be    = BW'(3) << iMemAddr[1:0];
            end
            default: begin
                st_wdata = iMemData;
                st_be    = '1;
            end
        endcase
    end

    assign ld_shift = iDmemRData >> {op_off, 3'b000};

    always_comb begin
        case (op_f3)
            3'b000:  ld_data = {{(pXLEN-8){ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{(pXLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {{(pXLEN-8){1'b0}}, ld_shift[7:0]};
            3'b101:  ld_data = {{(pXLEN-16){1'b0}}, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        op_load_nxt  = op_load;
        op_f3_nxt    = op_f3;
        op_off_nxt   = op_off;
        req_nxt      = oDmemReq;
        we_nxt       = oDmemWe;
        addr_nxt     = oDmemAddr;
        wdata_nxt    = oDmemWData;
        be_nxt       = oDmemBe;
        regdv_nxt    = 1'b0;
        regaddr_nxt  = oRegAddr;
        regdata_nxt  = oRegData;
        err_nxt      = 1'b0;
        errcode_nxt  = 2'b00;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!width_ok) begin
                        err_nxt     = 1'b1;
                        errcode_nxt = 2'b10;
                    end else if (misal) begin
                        err_nxt     = 1'b1;
                        errcode_nxt = 2'b01;
                    end else begin
                        state_nxt    = BUSREQ;
                        wait_cnt_nxt = '0;
                        req_nxt      = 1'b1;
                        we_nxt       = ~iMemRead;
                        addr_nxt     = {iMemAddr[pXLEN-1:2], 2'b00};
                        wdata_nxt    = iMemRead ? '0 : st_wdata;
                        be_nxt       = iMemRead ? '1 : st_be;
                        op_load_nxt  = iMemRead;
                        op_f3_nxt    = iMemOpType;
                        op_off_nxt   = iMemAddr[1:0];
                        regaddr_nxt  = iMemRdAddr;
                    end
                end
            end
            BUSREQ: begin
                // Ack is checked before the limit so a last-cycle ack still completes.
                if (iDmemAck) begin
                    req_nxt = 1'b0;
                    we_nxt  = 1'b0;
                    if (op_load) begin
                        state_nxt   = WB;
                        regdv_nxt   = 1'b1;
                        regdata_nxt = ld_data;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (wait_cnt == MAX_WAIT) begin
                    req_nxt     = 1'b0;
                    we_nxt      = 1'b0;
                    err_nxt     = 1'b1;
                    errcode_nxt = 2'b11;
                    state_nxt   = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            op_load    <= 1'b0;
            op_f3      <= '0;
            op_off     <= '0;
            oDmemReq   <= 1'b0;
            oDmemWe    <= 1'b0;
            oDmemAddr  <= '0;
            oDmemWData <= '0;
            oDmemBe    <= '0;
            oRegDv     <= 1'b0;
            oRegAddr   <= '0;
            oRegData   <= '0;
            oErr       <= 1'b0;
            oErrCode   <= '0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            op_load    <= op_load_nxt;
            op_f3      <= op_f3_nxt;
            op_off     <= op_off_nxt;
            oDmemReq   <= req_nxt;
            oDmemWe    <= we_nxt;
            oDmemAddr  <= addr_nxt;
            oDmemWData <= wdata_nxt;
            oDmemBe    <= be_nxt;
            oRegDv     <= regdv_nxt;
            oRegAddr   <= regaddr_nxt;
            oRegData   <= regdata_nxt;
            oErr       <= err_nxt;
            oErrCode   <= errcode_nxt;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected bus requests, write-backs and faults are queued at
// issue time and compared as the DUT produces them.
module tb_mem_access_unit;
    localparam int MAXW = 15;

    logic        iClk, iRst;
    logic        iMemDv, iMemRead, iMemWrite;
    logic [31:0] iMemAddr, iMemData;
    logic [2:0]  iMemOpType;
    logic [4:0]  iMemRdAddr;
    logic        oBusy, oDmemReq, oDmemWe;
    logic [31:0] oDmemAddr, oDmemWData;
    logic [3:0]  oDmemBe;
    logic        iDmemAck;
    logic [31:0] iDmemRData;
    logic        oRegDv;
    logic [4:0]  oRegAddr;
    logic [31:0] oRegData;
    logic        oErr;
    logic [1:0]  oErrCode;

    mem_access_unit #(.pXLEN(32), .pMaxWait(MAXW)) dut (
        .iClk(iClk), .iRst(iRst), .iMemDv(iMemDv), .iMemRead(iMemRead), .iMemWrite(iMemWrite),
        .iMemAddr(iMemAddr), .iMemData(iMemData), .iMemOpType(iMemOpType), .iMemRdAddr(iMemRdAddr),
        .oBusy(oBusy), .oDmemReq(oDmemReq), .oDmemWe(oDmemWe), .oDmemAddr(oDmemAddr),
        .oDmemWData(oDmemWData), .oDmemBe(oDmemBe), .iDmemAck(iDmemAck), .iDmemRData(iDmemRData),
        .oRegDv(oRegDv), .oRegAddr(oRegAddr), .oRegData(oRegData), .oErr(oErr), .oErrCode(oErrCode)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          len;
    } bus_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    bus_t       bus_q[$];
    wb_t        wb_q[$];
    logic [1:0] err_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: pops expectations as outputs appear, and measures request length.
    int   req_cnt  = 0;
    int   exp_len  = 0;
    logic prev_req = 1'b0;
    always @(negedge iClk) begin
        if (!iRst) begin
            req_cnt  = 0;
            prev_req = 1'b0;
        end else begin
            if (oDmemReq && !prev_req) begin
                req_cnt = 0;
                if (bus_q.size() == 0) begin
                    chk("unexp_req", 32'(oDmemReq), 32'd0);
                end else begin
                    bus_t e;
                    e = bus_q.pop_front();
                    exp_len = e.len;
                    chk("req_addr", oDmemAddr, e.addr);
                    chk("req_we", 32'(oDmemWe), 32'(e.we));
                    chk("req_be", 32'(oDmemBe), 32'(e.be));
                    chk("req_wdata", oDmemWData, e.wdata);
                    chk("req_busy", 32'(oBusy), 32'd1);
                end
            end
            if (oDmemReq) req_cnt++;
            if (!oDmemReq && prev_req) chk("req_len", 32'(req_cnt), 32'(exp_len));
            if (oRegDv) begin
                chk("wb_lat", 32'(prev_req), 32'd1);
                if (wb_q.size() == 0) begin
                    chk("unexp_wb", 32'(oRegDv), 32'd0);
                end else begin
                    wb_t w;
                    w = wb_q.pop_front();
                    chk("wb_rd", 32'(oRegAddr), 32'(w.rd));
                    chk("wb_data", oRegData, w.data);
                end
            end
            if (oErr) begin
                if (err_q.size() == 0) chk("unexp_err", 32'(oErr), 32'd0);
                else                   chk("err_code", 32'(oErrCode), 32'(err_q.pop_front()));
            end
            prev_req = oDmemReq;
        end
    end

    // Issues one op. ack_at: request cycle carrying the ack (0 = never). rst_at: request cycle to reset in.
    task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] f3, input logic [4:0] rdaddr, input int ack_at,
                         input logic [31:0] rdata, input int rst_at);
        int          size, o;
        bit          legal, mis, fault;
        bus_t        b;
        logic [31:0] w, v;
        size  = 1 << f3[1:0];
        o     = int'(addr[1:0]);
        legal = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        mis   = (o % size) != 0;
        fault = !legal || mis;
        if (!legal)   err_q.push_back(2'b10);
        else if (mis) err_q.push_back(2'b01);
        else begin
            b.addr = {addr[31:2], 2'b00};
            b.we   = !rd;
            b.len  = (ack_at == 0) ? MAXW + 1 : ack_at;
            b.be   = 4'h0;
            b.wdata = 32'h0;
            if (rd) begin
                b.be = 4'hF;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (i >= o && i < o + size) b.be[i] = 1'b1;
                    b.wdata[8*i +: 8] = data[8*(i % size) +: 8];
                end
            end
            bus_q.push_back(b);
            if (rst_at == 0) begin
                if (!rd) begin
                end else if (ack_at == 0) begin
                    err_q.push_back(2'b11);
                end else begin
                    w = rdata >> (8 * o);
                    if (size == 1)      v = w & 32'hFF;
                    else if (size == 2) v = w & 32'hFFFF;
                    else                v = w;
                    if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
                    if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
                    wb_q.push_back('{rdaddr, v});
                end
            end
        end

        @(negedge iClk);
        for (int n = 0; n < 50 && oBusy; n++) @(negedge iClk);
        iMemDv = 1'b1; iMemRead = rd; iMemWrite = wr;
        iMemAddr = addr; iMemData = data; iMemOpType = f3; iMemRdAddr = rdaddr;
        @(posedge iClk);
        #1;
        iMemDv = 1'b0; iMemRead = 1'b0; iMemWrite = 1'b0;
        iMemAddr = $urandom; iMemData = $urandom;
        if (fault) return;

        for (int k = 1; k <= 300; k++) begin
            @(negedge iClk);
            if (!oDmemReq) break;
            if (k == rst_at) begin
                iRst = 1'b0;
                #1;
                chk("rst_req", 32'(oDmemReq), 32'd0);
                chk("rst_busy", 32'(oBusy), 32'd0);
                @(negedge iClk);
                @(negedge iClk);
                iRst = 1'b1;
                @(negedge iClk);
                chk("post_rst_busy", 32'(oBusy), 32'd0);
                return;
            end
            iDmemAck   = (k == ack_at);
            iDmemRData = (k == ack_at) ? rdata : $urandom;
            @(posedge iClk);
            #1;
            iDmemAck = 1'b0;
            if (k == ack_at) break;
        end
    endtask

    initial begin
        iRst = 1'b0; iMemDv = 1'b0; iMemRead = 1'b0; iMemWrite = 1'b0;
        iMemAddr = '0; iMemData = '0; iMemOpType = '0; iMemRdAddr = '0;
        iDmemAck = 1'b0; iDmemRData = '0;
        #12;
        chk("rst_busy0", 32'(oBusy), 32'd0);
        chk("rst_req0", 32'(oDmemReq), 32'd0);
        chk("rst_regdv0", 32'(oRegDv), 32'd0);
        chk("rst_err0", 32'(oErr), 32'd0);
        chk("rst_be0", 32'(oDmemBe), 32'd0);
        @(negedge iClk);
        iRst = 1'b1;

        //    rd wr  addr          data          f3    rd  ack  rdata         rst
        do_op(1, 0, 32'h100, 32'h0,        3'd2, 5'd5, 3,  32'hDEADBEEF, 0);
        do_op(1, 0, 32'h103, 32'h0,        3'd0, 5'd6, 1,  32'h80FF0000, 0);
        do_op(1, 0, 32'h103, 32'h0,        3'd4, 5'd7, 1,  32'h80FF0000, 0);
        do_op(1, 0, 32'h102, 32'h0,        3'd1, 5'd8, 2,  32'h80FF0000, 0);
        do_op(1, 0, 32'h102, 32'h0,        3'd5, 5'd0, 1,  32'h80FF0000, 0);
        do_op(0, 1, 32'h201, 32'h12345678, 3'd0, 5'd0, 2,  32'h0,        0);
        do_op(0, 1, 32'h202, 32'hAABBCCDD, 3'd1, 5'd0, 1,  32'h0,        0);
        do_op(0, 1, 32'h304, 32'hCAFEF00D, 3'd2, 5'd0, 4,  32'h0,        0);
        do_op(0, 1, 32'h302, 32'hCAFEF00D, 3'd2, 5'd0, 1,  32'h0,        0);
        do_op(1, 0, 32'h100, 32'h0,        3'd3, 5'd3, 1,  32'h0,        0);
        do_op(1, 0, 32'h101, 32'h0,        3'd3, 5'd3, 1,  32'h0,        0);
        do_op(0, 1, 32'h100, 32'h0,        3'd4, 5'd0, 1,  32'h0,        0);
        do_op(1, 0, 32'h101, 32'h0,        3'd1, 5'd3, 1,  32'h0,        0);
        do_op(1, 0, 32'h140, 32'h0,        3'd2, 5'd9, 0,  32'h0,        0);
        do_op(1, 0, 32'h144, 32'h0,        3'd2, 5'd10, MAXW + 1, 32'h13572468, 0);
        do_op(1, 0, 32'h500, 32'h0,        3'd2, 5'd11, 0, 32'h0,        3);
        do_op(1, 0, 32'h400, 32'h0,        3'd2, 5'd12, 1, 32'hA5A5_5A5A, 0);
        do_op(1, 1, 32'h600, 32'h11111111, 3'd2, 5'd13, 2, 32'h5555AAAA, 0);

        repeat (5) @(negedge iClk);
        chk("bus_q_left", 32'(bus_q.size()), 32'd0);
        chk("wb_q_left", 32'(wb_q.size()), 32'd0);
        chk("err_q_left", 32'(err_q.size()), 32'd0);
        chk("end_busy", 32'(oBusy), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog got=running exp=finished t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage sitting directly downstream of the execute ALU: it consumes the ALU's registered load/store operation (address, store data, funct3 width code, destination register, read/write strobes), runs one transaction on the data-memory request/acknowledge bus, and produces a register write-back for loads. It performs byte-lane alignment, byte-enable generation, load sign/zero extension, alignment checking, and a bus-timeout watchdog. While a transaction is open it stalls the upstream pipeline.

## Interface

- pXLEN, 32, data/address width. Only 32 is supported; byte-enable width is pXLEN/8.
- pMaxWait, 15, number of cycles in BUSREQ without acknowledge before a timeout. Range 1..255.

- iClk  in  1  core clock; all state is updated on its rising edge.
- iRst  in  1  reset, asynchronous, active-low.
- iMemDv  in  1  operation valid from the ALU stage.
- iMemRead  in  1  load strobe.
- iMemWrite  in  1  store strobe.
- iMemAddr  in  pXLEN  byte address (rs1 + imm).
- iMemData  in  pXLEN  store data (rs2).
- iMemOpType  in  3  funct3 width code.
- iMemRdAddr  in  5  load destination register.
- oBusy  out  1  stall to upstream; equals state != IDLE.
- oDmemReq  out  1  bus request.
- oDmemWe  out  1  1 = write.
- oDmemAddr  out  pXLEN  word-aligned address {addr[31:2], 2'b00}.
- oDmemWData  out  pXLEN  lane-replicated store data.
- oDmemBe  out  4  byte enables.
- iDmemAck  in  1  bus acknowledge; sampled only while oDmemReq = 1.
- iDmemRData  in  pXLEN  read data, valid on the cycle iDmemAck = 1.
- oRegDv  out  1  one-cycle write-back strobe.
- oRegAddr  out  5  write-back register.
- oRegData  out  pXLEN  extended load result.
- oErr  out  1  one-cycle fault pulse.
- oErrCode  out  2  fault code: 01 misaligned, 10 illegal width, 11 timeout. Valid only while oErr = 1.

## Operation

**Reset**
- While iRst = 0, all outputs are 0, state is IDLE, and the wait counter is 0.

**Accept**
- A command is accepted in IDLE when iMemDv = 1 and (iMemRead | iMemWrite) = 1.
- If both strobes are set, the command is a load.
- In any state other than IDLE, iMemDv is ignored. Upstream holds its operation while oBusy = 1.

**Checks at accept (no bus request is issued on failure)**
- Illegal width:
  - loads allow funct3 ∈ {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}
  - stores allow funct3 ∈ {000 SB, 001 SH, 010 SW}
  - anything else → oErr = 1, oErrCode = 10.
- Misalignment: halfword with addr[0] = 1, or word with addr[1:0] ≠ 00 → oErr = 1, oErrCode = 01.
- If both checks fail, illegal width takes priority.
- On a fault, the next state is IDLE.

**Store lanes (offset o = addr[1:0])**
- SB: WData = {4{data[7:0]}}, Be = 0001 << o.
- SH: WData = {2{data[15:0]}}, Be = 0011 << o.
- SW: WData = data, Be = 1111.
- Loads drive Be = 1111 and WData = 0.

**Load extraction**
- The read word is shifted right by 8·o.
- LB / LH sign-extend from bit 7 / bit 15.
- LBU / LHU zero-extend.
- LW passes the word unchanged.
- rdAddr = 0 still produces an oRegDv pulse; the register file discards writes to x0.

**State machine**
- IDLE → BUSREQ on a valid accept; → IDLE on a fault.
- BUSREQ:
  - oDmemReq, We, Addr, WData, and Be are held stable until the acknowledge.
  - On iDmemAck: a load latches the extended data, then goes to WB. A store goes to IDLE.
  - With no acknowledge, the wait counter increments. When the counter reaches pMaxWait, the request drops, oErr = 1 with oErrCode = 11, and the next state is IDLE.
  - If the acknowledge arrives on the same cycle the counter reaches its limit, the acknowledge wins and no timeout is flagged.
- WB: oRegDv = 1 for exactly one cycle with oRegAddr and oRegData valid, then IDLE.
- The wait counter clears on every transition into BUSREQ.

## Timing

- All outputs are registered.
- Command accepted at edge T: oDmemReq = 1 and oBusy = 1 from T+1.
- Earliest acknowledge is sampled at edge T+2 (ack asserted during the first request cycle). oDmemReq is 0 after that edge.
- Load write-back: oRegDv is high during the cycle after edge T+2, i.e. 2 cycles after the accept cycle at the earliest. oBusy is low one cycle later.
- Store: oBusy falls after the acknowledge edge, giving a 1-cycle bus occupancy at minimum.
- Faults at accept: oErr pulses for the cycle after edge T; oBusy stays 0 and a new command may be accepted on the next edge.
- Timeout: oErr pulses for one cycle, pMaxWait+1 cycles after oDmemReq rose.
- Reset mid-transaction: oDmemReq and all other outputs drop immediately (asynchronously). The transaction is abandoned and no write-back or error is produced.
- Back-to-back operation is possible: a new accept can occur in the cycle oBusy returns to 0.

## Test plan

- LW to addr 0x100, ack after 3 cycles with RData 0xDEADBEEF, rd = 5 → Be = 1111, Addr = 0x100; a single oRegDv with oRegAddr = 5 and oRegData = 0xDEADBEEF; no oErr.
- LB / LBU at 0x103 with RData 0x80FF_0000 → 0xFFFFFF80 / 0x00000080. LH at 0x102 → 0xFFFF80FF.
- SB at 0x201 with data 0x12345678 → Addr = 0x200, Be = 0010, WData = 0x78787878, We = 1; no oRegDv.
- SW at 0x302 → oErr = 1, oErrCode = 01, no oDmemReq. Load with funct3 = 011 → oErrCode = 10.
- Load with the acknowledge never asserted, pMaxWait = 15 → request held for 16 cycles, then oErr with code 11. Repeat with the acknowledge on exactly the 16th request cycle → normal write-back, no error.
- iRst pulsed low while in BUSREQ → oDmemReq drops immediately, no oRegDv. After release, oBusy = 0 and a new command is accepted.
